// File: rtl/folding_2_inverse.sv
// -----------------------------------------------------------------------------
// folding_2_inverse
//
// Purpose:
//   2-folded inverse (equaliser) of the second-order recursive section
//       y(n) = x(n) + a*y(n-1) + b*y(n-2)
//   The block recovers the section input from its output:
//       Xn(n) = Yn(n) - a*Yn(n-1) - b*Yn(n-2)
//   One multiplier and one subtractor are shared over two phases:
//   MUL_A forms Yn - a*y1 and MUL_B forms that result minus b*y2.
//   The block therefore accepts at most one sample every 2 clocks.
//   All arithmetic is modulo 2^n. Products are full 2n-bit signed
//   products truncated to n bits. Subtraction wraps. This keeps the
//   block bit-exact with the forward section, so a round trip is lossless.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous, active-high reset
//   Yn         in   n  filtered sample to invert (signed)
//   a          in   n  first-tap coefficient (signed), latched per sample
//   b          in   n  second-tap coefficient (signed), latched per sample
//   in_valid   in   1  Yn/a/b valid this cycle
//   in_ready   out  1  block accepts a sample this cycle (combinational)
//   Xn         out  n  recovered sample (signed, registered)
//   out_valid  out  1  one-cycle pulse, Xn updated
// -----------------------------------------------------------------------------
module folding_2_inverse #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] Yn,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [n-1:0] Xn,
  output logic         out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2
  } state_t;

  // Forms the full 2n-bit signed product and keeps only the low n bits.
  // Sign-extending both operands to 2n bits makes the unsigned 2n-bit
  // product equal to the signed product modulo 2^(2n).
  function automatic logic [n-1:0] mul_trunc(input logic [n-1:0] x,
                                             input logic [n-1:0] y);
    logic [2*n-1:0] xw;
    logic [2*n-1:0] yw;
    xw = {{n{x[n-1]}}, x};
    yw = {{n{y[n-1]}}, y};
    return n'(xw * yw);
  endfunction

  // Computes a wrapping n-bit subtraction with no saturation.
  function automatic logic [n-1:0] sub_wrap(input logic [n-1:0] x,
                                            input logic [n-1:0] y);
    return x - y;
  endfunction

  state_t       state_r;
  state_t       state_next_s;

  logic [n-1:0] yreg_r;
  logic [n-1:0] a_r;
  logic [n-1:0] b_r;
  logic [n-1:0] y1_r;
  logic [n-1:0] y2_r;
  logic [n-1:0] acc_r;

  logic         in_ready_s;
  logic         accept_s;
  logic [n-1:0] mul_coef_s;
  logic [n-1:0] mul_hist_s;
  logic [n-1:0] minuend_s;
  logic [n-1:0] prod_s;
  logic [n-1:0] diff_s;

  // Decodes readiness from state: a new sample may land in IDLE or on the
  // MUL_B edge that retires the current sample.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      MUL_A:   in_ready_s = 1'b0;
      MUL_B:   in_ready_s = 1'b1;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;
  assign accept_s = in_valid & in_ready_s;

  // Selects the operands of the shared multiplier and subtractor by phase.
  always_comb begin
    mul_coef_s = a_r;
    mul_hist_s = y1_r;
    minuend_s  = yreg_r;
    if (state_r == MUL_B) begin
      mul_coef_s = b_r;
      mul_hist_s = y2_r;
      minuend_s  = acc_r;
    end else begin
      mul_coef_s = a_r;
      mul_hist_s = y1_r;
      minuend_s  = yreg_r;
    end
  end

  // Holds the single shared multiplier and single shared subtractor.
  assign prod_s = mul_trunc(mul_coef_s, mul_hist_s);
  assign diff_s = sub_wrap(minuend_s, prod_s);

  // Computes the next state. An accept on the MUL_B edge chains directly
  // into MUL_A, which gives 2 clocks per sample when streaming.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = MUL_A;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL_A: begin
        state_next_s = MUL_B;
      end
      MUL_B: begin
        if (accept_s) begin
          state_next_s = MUL_A;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Holds the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Captures the sample and its coefficients on accept. Coefficients are
  // latched per sample, so later changes on a/b do not affect it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yreg_r <= {n{1'b0}};
      a_r    <= {n{1'b0}};
      b_r    <= {n{1'b0}};
    end else if (accept_s) begin
      yreg_r <= Yn;
      a_r    <= a;
      b_r    <= b;
    end else begin
      yreg_r <= yreg_r;
      a_r    <= a_r;
      b_r    <= b_r;
    end
  end

  // Stores the phase-0 partial result Yn - a*y1 for use in phase 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= {n{1'b0}};
    end else if (state_r == MUL_A) begin
      acc_r <= diff_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Shifts the output history when a sample retires. y1 takes the old
  // yreg (non-blocking), so a sample accepted on this same edge pairs
  // with the just-retired sample in its MUL_A phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1_r <= {n{1'b0}};
      y2_r <= {n{1'b0}};
    end else if (state_r == MUL_B) begin
      y2_r <= y1_r;
      y1_r <= yreg_r;
    end else begin
      y2_r <= y2_r;
      y1_r <= y1_r;
    end
  end

  // Registers the recovered sample and pulses out_valid on MUL_B completion.
  // Xn holds its value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Xn        <= {n{1'b0}};
      out_valid <= 1'b0;
    end else if (state_r == MUL_B) begin
      Xn        <= diff_s;
      out_valid <= 1'b1;
    end else begin
      Xn        <= Xn;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_folding_2_inverse.sv
// -----------------------------------------------------------------------------
// tb_folding_2_inverse
//
// Self-checking bench for folding_2_inverse. Expected outputs are the
// original section inputs x(n). For random traffic, the bench pushes each
// x(n) through its own forward recursion to produce Yn. Every accepted
// sample is queued with its due edge (accept + 2). Each cycle, the bench
// checks in_ready, out_valid and Xn against that queue.
// -----------------------------------------------------------------------------
module tb_folding_2_inverse;

  logic        clk;
  logic        rst;
  logic [15:0] Yn;
  logic [15:0] a;
  logic [15:0] b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Xn;
  logic        out_valid;

  folding_2_inverse #(.n(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Yn        (Yn),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Xn        (Xn),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] x;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          ecnt     = 0;
  logic        prev_acc = 1'b0;
  logic [15:0] last_x   = 16'd0;
  logic [15:0] fy1      = 16'd0;
  logic [15:0] fy2      = 16'd0;
  logic [15:0] a_cur, b_cur, x_cur, y_cur;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock: drive inputs, advance, then compare against the model.
  task automatic tick(input logic v, input logic [15:0] y, input logic [15:0] ca,
                      input logic [15:0] cb, input logic [15:0] want_x,
                      output logic accepted);
    logic acc;
    exp_t e;
    in_valid = v;
    Yn       = y;
    a        = ca;
    b        = cb;
    // The block is busy exactly one cycle after each accept.
    acc = v && !prev_acc;
    @(posedge clk);
    #1;
    ecnt++;
    if (acc) begin
      e.due = ecnt + 2;
      e.x   = want_x;
      q.push_back(e);
    end
    chk("in_ready", {15'd0, in_ready}, {15'd0, !acc});
    prev_acc = acc;
    if (q.size() > 0 && q[0].due == ecnt) begin
      chk("out_valid_pulse", {15'd0, out_valid}, 16'd1);
      chk("Xn_value", Xn, q[0].x);
      last_x = q[0].x;
      q.delete(0);
    end else begin
      chk("out_valid_idle", {15'd0, out_valid}, 16'd0);
      chk("Xn_hold", Xn, last_x);
    end
    accepted = acc;
  endtask

  task automatic idle(input int cycles);
    logic dummy;
    for (int i = 0; i < cycles; i++) begin
      tick(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, dummy);
    end
  endtask

  // Presents one sample, holding it until it is accepted (bounded).
  task automatic send(input logic [15:0] y, input logic [15:0] ca,
                      input logic [15:0] cb, input logic [15:0] want_x);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick(1'b1, y, ca, cb, want_x, got);
    end
    checks++;
    assert (got === 1'b1) else begin
      failures++;
      $error("FAIL send_timeout observed=%0b expected=1", got);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    #2;
    chk("rst_Xn", Xn, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    @(posedge clk);
    #1;
    ecnt++;
    chk("rst_hold_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_hold_Xn", Xn, 16'd0);
    rst = 1'b0;
    q.delete();
    last_x   = 16'd0;
    prev_acc = 1'b0;
    fy1      = 16'd0;
    fy2      = 16'd0;
  endtask

  // Draws the next random sample and runs it through the forward section.
  task automatic new_sample();
    if ($urandom_range(0, 7) == 0) begin
      a_cur = 16'($urandom);
      b_cur = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
    end
    x_cur = 16'($urandom);
    y_cur = 16'(longint'($signed(x_cur))
              + longint'($signed(a_cur)) * longint'($signed(fy1))
              + longint'($signed(b_cur)) * longint'($signed(fy2)));
  endtask

  initial begin
    #1000000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic got;
    rst      = 1'b1;
    in_valid = 1'b0;
    Yn       = 16'd0;
    a        = 16'd0;
    b        = 16'd0;

    // Reset, then no pulse without in_valid.
    do_reset();
    idle(3);

    // Back-to-back round trip, a=2, b=3.
    send(-16'sd3,  16'd2, 16'd3, -16'sd3);
    send(-16'sd1,  16'd2, 16'd3,  16'sd5);
    send(-16'sd9,  16'd2, 16'd3,  16'sd2);
    send(-16'sd23, 16'd2, 16'd3, -16'sd2);
    idle(3);

    // Gapped: one sample per 5 clocks, same stream.
    do_reset();
    send(-16'sd3,  16'd2, 16'd3, -16'sd3); idle(4);
    send(-16'sd1,  16'd2, 16'd3,  16'sd5); idle(4);
    send(-16'sd9,  16'd2, 16'd3,  16'sd2); idle(4);
    send(-16'sd23, 16'd2, 16'd3, -16'sd2); idle(4);

    // Ignored request while busy (MUL_A): Yn=7 must not be captured.
    do_reset();
    send(-16'sd3, 16'd2, 16'd3, -16'sd3);
    tick(1'b1, 16'd7, 16'd2, 16'd3, 16'd7, got);
    send(-16'sd1,  16'd2, 16'd3,  16'sd5);
    send(-16'sd9,  16'd2, 16'd3,  16'sd2);
    send(-16'sd23, 16'd2, 16'd3, -16'sd2);
    idle(3);

    // Modulo wrap of the product: 0x4000*4 wraps to 0.
    do_reset();
    send(16'd4, 16'h4000, 16'd0, 16'd4);
    send(16'd4, 16'h4000, 16'd0, 16'd4);
    idle(3);

    // Mid-operation reset discards the in-flight sample and clears history.
    do_reset();
    send(-16'sd1, 16'd2, 16'd3, -16'sd1);
    idle(1);
    do_reset();
    idle(2);
    send(16'sd5, 16'd2, 16'd3, 16'sd5);
    idle(3);

    // Randomized round trip with random gaps and coefficient changes.
    do_reset();
    a_cur = 16'($urandom);
    b_cur = 16'($urandom);
    new_sample();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 3) != 0), y_cur, a_cur, b_cur, x_cur, got);
      if (got) begin
        fy2 = fy1;
        fy1 = y_cur;
        new_sample();
      end else if ($urandom_range(0, 149) == 0) begin
        do_reset();
        new_sample();
      end
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
